commit_cmp: RTL
===============

Name: commit_cmp

Overview:
Lockstep retirement checker downstream of the reference core model's commit-trace outputs (pc, instr, rd, rd data, stall).
- Each cycle it accepts one commit from the reference model and one from the RTL core under test.
- Each stream is buffered in its own FIFO, so the two cores may retire with different timing.
- Heads are compared in order; the first divergence is reported with full context, and commit/mismatch counts are kept for the bench's end-of-run summary.

Parameters:
XLEN, 32, data/pc/instr width
DEPTH, 8, entries per side FIFO (power of two, >=2)
CNT_W, 32, width of commit counter
HALT_ON_ERR, 1, 1 = stop comparing after first mismatch; 0 = keep comparing and counting

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear: flush FIFOs, flags, counters, state->RUN
ref_valid_i  in  1  reference commit present this cycle
ref_stall_i  in  1  reference entry is a stall slot (not a retirement)
ref_pc_i / ref_instr_i  in  XLEN each  reference pc, instruction
ref_rd_i  in  5  reference destination reg (0 = no write)
ref_data_i  in  XLEN  reference write data
dut_valid_i, dut_pc_i, dut_instr_i, dut_rd_i, dut_data_i  in  1/XLEN/XLEN/5/XLEN  same fields for core under test (no stall input)
err_o  out  1  sticky: first mismatch seen
ovf_o  out  1  sticky: push to full FIFO dropped
err_pc_o / err_ref_instr_o / err_dut_instr_o  out  XLEN each  captured on first mismatch
err_ref_data_o / err_dut_data_o  out  XLEN each  captured on first mismatch
err_ref_rd_o / err_dut_rd_o  out  5 each  captured on first mismatch
commit_cnt_o  out  CNT_W  compared pairs
mismatch_cnt_o  out  CNT_W  mismatching pairs
ref_level_o / dut_level_o  out  $clog2(DEPTH)+1 each  FIFO occupancy

Behaviour:
- Reset (rstn_i low, asynchronous): all outputs 0, FIFO pointers 0, state RUN. clr_i has the same effect synchronously and takes priority over all other activity in that cycle.
- Push, reference side: ref_valid_i && !ref_stall_i. Stall slots are never pushed.
- Push, DUT side: dut_valid_i.
- A push is accepted when the FIFO is not full, or when a pop of that FIFO occurs in the same cycle.
- Otherwise the entry is dropped and ovf_o sets. In HALT state, drops do not set ovf_o.
- States: RUN, HALT.
- RUN: when both FIFOs are non-empty, both heads pop in the same cycle.
- A pair matches iff pc equal, instr equal, rd equal, and (rd==0 or data equal). Data is ignored when rd==0.
- Result is registered; counters and flags update on the cycle after the pop.
- On each compared pair, commit_cnt_o +1. On a mismatch, mismatch_cnt_o +1.
- First mismatch only: err_o sets and all err_* fields are captured from the compared pair. err_pc_o takes the reference pc. Later mismatches never overwrite captured fields.
- If HALT_ON_ERR=1, the first mismatch moves RUN->HALT.
- HALT: no pops, no compares. Pushes continue until full. Exit only via reset or clr_i.
- Counters saturate at all-ones; they do not wrap.
- FIFO pointers wrap modulo DEPTH, with an extra wrap bit for full/empty.
- Level outputs are combinational from the pointers and range 0..DEPTH.
- Simultaneous push and pop on a full FIFO: the pop frees the slot, the push is accepted, and the level is unchanged.
- Reset asserted mid-compare: the pending registered result is discarded.

Optional Feature:
COMMIT_CMP_TIMEOUT_EN: adds parameter TIMEOUT (default 64) and output to_o (1, sticky).
- In RUN, a counter increments each cycle that exactly one FIFO is non-empty. It clears on any pop, or when both FIFOs are empty.
- When the counter reaches TIMEOUT, to_o sets and the state goes to HALT regardless of HALT_ON_ERR.
- Without the macro: no counter, no to_o port, no timeout transition.

Test Plan:
- Identical streams: 20 commits on both sides, same cycles, pc 0x0..0x4C step 4, rd 1..20 -> commit_cnt_o=20, err_o=0, levels return to 0.
- Skewed timing: reference 10 commits back-to-back, DUT same 10 commits delayed 5 cycles, DEPTH=8 -> ref_level_o peaks at 6, commit_cnt_o=10, no err_o, no ovf_o.
- Data mismatch: 4th pair ref_data 0x00000005, dut_data 0x00000006, rd=3, HALT_ON_ERR=1 -> err_o high one cycle after pop, err_pc_o=ref pc, captured data 5/6, commit_cnt_o=4, no further compares.
- Stall and x0: reference stall slots interleaved and ignored; pair with rd=0 and differing data -> counted as match, err_o=0.
- Overflow and clear: DUT idle, 9 reference commits, DEPTH=8 -> ovf_o=1, ref_level_o=8; clr_i pulse -> all outputs 0, RUN.
- Reset mid-run: rstn_i low while a pop's result is pending -> counters remain 0 after reset release.

Source files
------------

// File: rtl/commit_cmp.sv
// commit_cmp: lockstep retirement checker.
// The reference model and the core under test each deliver one commit per cycle
// into a private FIFO, so the two streams may retire with different timing. The
// FIFO heads are popped and compared in order. The compare result is registered
// and applied to the counters and error capture on the following cycle. The first
// divergence is latched with full context.
//
// Optional build macro: COMMIT_CMP_TIMEOUT_EN adds parameter TIMEOUT and output
// to_o. It flags, and halts on, one stream stalling while the other has
// entries waiting.
//
// Ports:
//   clk_i, rstn_i      clock, asynchronous active-low reset
//   clr_i              synchronous clear of FIFOs, flags, counters and state
//   ref_*_i            reference commit: valid, stall slot, pc, instr, rd, data
//   dut_*_i            core-under-test commit: valid, pc, instr, rd, data
//   err_o / ovf_o      sticky first-mismatch / dropped-push flags
//   err_*_o            context of the first mismatching pair
//   commit_cnt_o       compared pairs (saturating)
//   mismatch_cnt_o     mismatching pairs (saturating)
//   ref/dut_level_o    FIFO occupancy, 0..DEPTH, combinational
//   to_o               (COMMIT_CMP_TIMEOUT_EN only) sticky timeout flag
module commit_cmp #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned HALT_ON_ERR = 1
`ifdef COMMIT_CMP_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT     = 64
`endif
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    clr_i,
    input  logic                    ref_valid_i,
    input  logic                    ref_stall_i,
    input  logic [XLEN-1:0]         ref_pc_i,
    input  logic [XLEN-1:0]         ref_instr_i,
    input  logic [4:0]              ref_rd_i,
    input  logic [XLEN-1:0]         ref_data_i,
    input  logic                    dut_valid_i,
    input  logic [XLEN-1:0]         dut_pc_i,
    input  logic [XLEN-1:0]         dut_instr_i,
    input  logic [4:0]              dut_rd_i,
    input  logic [XLEN-1:0]         dut_data_i,
    output logic                    err_o,
    output logic                    ovf_o,
    output logic [XLEN-1:0]         err_pc_o,
    output logic [XLEN-1:0]         err_ref_instr_o,
    output logic [XLEN-1:0]         err_dut_instr_o,
    output logic [XLEN-1:0]         err_ref_data_o,
    output logic [XLEN-1:0]         err_dut_data_o,
    output logic [4:0]              err_ref_rd_o,
    output logic [4:0]              err_dut_rd_o,
    output logic [CNT_W-1:0]        commit_cnt_o,
    output logic [CNT_W-1:0]        mismatch_cnt_o,
    output logic [$clog2(DEPTH):0]  ref_level_o,
    output logic [$clog2(DEPTH):0]  dut_level_o
`ifdef COMMIT_CMP_TIMEOUT_EN
    ,
    output logic                    to_o
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    state_t          state_q;
    state_t          state_d;

    entry_t          ref_mem [DEPTH];
    entry_t          dut_mem [DEPTH];
    logic [LW-1:0]   ref_wp_q;
    logic [LW-1:0]   ref_rp_q;
    logic [LW-1:0]   dut_wp_q;
    logic [LW-1:0]   dut_rp_q;

    entry_t          ref_in_c;
    entry_t          dut_in_c;
    entry_t          ref_head_c;
    entry_t          dut_head_c;
    logic            ref_empty_c;
    logic            dut_empty_c;
    logic            ref_full_c;
    logic            dut_full_c;
    logic            ref_push_req_c;
    logic            dut_push_req_c;
    logic            ref_push_c;
    logic            dut_push_c;
    logic            pop_c;
    logic            match_c;

    logic            cmp_vld_q;
    logic            cmp_mis_q;
    entry_t          cmp_ref_q;
    logic [XLEN-1:0] cmp_dut_instr_q;
    logic [4:0]      cmp_dut_rd_q;
    logic [XLEN-1:0] cmp_dut_data_q;

`ifdef COMMIT_CMP_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]   to_cnt_q;
    logic            to_wait_c;
    logic            to_hit_c;
`endif

    // Incoming entries and FIFO status; the extra pointer bit separates full from empty.
    assign ref_in_c    = '{pc: ref_pc_i, instr: ref_instr_i, rd: ref_rd_i, data: ref_data_i};
    assign dut_in_c    = '{pc: dut_pc_i, instr: dut_instr_i, rd: dut_rd_i, data: dut_data_i};
    assign ref_head_c  = ref_mem[ref_rp_q[AW-1:0]];
    assign dut_head_c  = dut_mem[dut_rp_q[AW-1:0]];
    assign ref_empty_c = (ref_wp_q == ref_rp_q);
    assign dut_empty_c = (dut_wp_q == dut_rp_q);
    assign ref_full_c  = (ref_wp_q[AW] != ref_rp_q[AW]) &&
                         (ref_wp_q[AW-1:0] == ref_rp_q[AW-1:0]);
    assign dut_full_c  = (dut_wp_q[AW] != dut_rp_q[AW]) &&
                         (dut_wp_q[AW-1:0] == dut_rp_q[AW-1:0]);
    assign ref_level_o = ref_wp_q - ref_rp_q;
    assign dut_level_o = dut_wp_q - dut_rp_q;

    // Stall slots are not retirements and never enter the reference FIFO.
    assign ref_push_req_c = ref_valid_i && !ref_stall_i;
    assign dut_push_req_c = dut_valid_i;
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
    assign ref_push_c     = ref_push_req_c && (!ref_full_c || pop_c);
    assign dut_push_c     = dut_push_req_c && (!dut_full_c || pop_c);

    // Write data is irrelevant to an x0 destination.
    assign match_c = (ref_head_c.pc    == dut_head_c.pc)    &&
                     (ref_head_c.instr == dut_head_c.instr) &&
                     (ref_head_c.rd    == dut_head_c.rd)    &&
                     ((ref_head_c.rd == 5'd0) || (ref_head_c.data == dut_head_c.data));

`ifdef COMMIT_CMP_TIMEOUT_EN
    // Exactly one side holding entries means the other stream has stopped retiring.
    assign to_wait_c = (state_q == ST_RUN) && (ref_empty_c != dut_empty_c);
    assign to_hit_c  = to_wait_c && (to_cnt_q == TW'(TIMEOUT - 1));
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and pop decision; the halt is taken on the mismatching pop itself
    // so no further pair is popped while its result is still in flight.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            ST_RUN: begin
                pop_c = !ref_empty_c && !dut_empty_c;
                if (pop_c && !match_c && (HALT_ON_ERR != 0)) begin
                    state_d = ST_HALT;
                end
`ifdef COMMIT_CMP_TIMEOUT_EN
                if (to_hit_c) begin
                    state_d = ST_HALT;
                end
`endif
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
        endcase
        if (clr_i) begin
            state_d = ST_RUN;
            pop_c   = 1'b0;
        end
    end

    // FIFO storage (no reset needed; pointers qualify the contents).
    always_ff @(posedge clk_i) begin
        if (ref_push_c && !clr_i) begin
            ref_mem[ref_wp_q[AW-1:0]] <= ref_in_c;
        end
        if (dut_push_c && !clr_i) begin
            dut_mem[dut_wp_q[AW-1:0]] <= dut_in_c;
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ref_wp_q <= '0;
            ref_rp_q <= '0;
            dut_wp_q <= '0;
            dut_rp_q <= '0;
        end else if (clr_i) begin
            ref_wp_q <= '0;
            ref_rp_q <= '0;
            dut_wp_q <= '0;
            dut_rp_q <= '0;
        end else begin
            if (ref_push_c) ref_wp_q <= ref_wp_q + LW'(1);
            if (dut_push_c) dut_wp_q <= dut_wp_q + LW'(1);
            if (pop_c) begin
                ref_rp_q <= ref_rp_q + LW'(1);
                dut_rp_q <= dut_rp_q + LW'(1);
            end
        end
    end

    // Compare stage: holds the popped pair and its verdict for one cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cmp_vld_q       <= 1'b0;
            cmp_mis_q       <= 1'b0;
            cmp_ref_q       <= '0;
            cmp_dut_instr_q <= '0;
            cmp_dut_rd_q    <= '0;
            cmp_dut_data_q  <= '0;
        end else if (clr_i) begin
            cmp_vld_q       <= 1'b0;
            cmp_mis_q       <= 1'b0;
            cmp_ref_q       <= '0;
            cmp_dut_instr_q <= '0;
            cmp_dut_rd_q    <= '0;
            cmp_dut_data_q  <= '0;
        end else begin
            cmp_vld_q <= pop_c;
            cmp_mis_q <= pop_c && !match_c;
            if (pop_c) begin
                cmp_ref_q       <= ref_head_c;
                cmp_dut_instr_q <= dut_head_c.instr;
                cmp_dut_rd_q    <= dut_head_c.rd;
                cmp_dut_data_q  <= dut_head_c.data;
            end
        end
    end

    // Counters, sticky flags and first-mismatch capture.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_o           <= 1'b0;
            ovf_o           <= 1'b0;
            err_pc_o        <= '0;
            err_ref_instr_o <= '0;
            err_dut_instr_o <= '0;
            err_ref_data_o  <= '0;
            err_dut_data_o  <= '0;
            err_ref_rd_o    <= '0;
            err_dut_rd_o    <= '0;
            commit_cnt_o    <= '0;
            mismatch_cnt_o  <= '0;
        end else if (clr_i) begin
            err_o           <= 1'b0;
            ovf_o           <= 1'b0;
            err_pc_o        <= '0;
            err_ref_instr_o <= '0;
            err_dut_instr_o <= '0;
            err_ref_data_o  <= '0;
            err_dut_data_o  <= '0;
            err_ref_rd_o    <= '0;
            err_dut_rd_o    <= '0;
            commit_cnt_o    <= '0;
            mismatch_cnt_o  <= '0;
        end else begin
            // Drops while halted are expected and not reported.
            if ((state_q == ST_RUN) &&
                ((ref_push_req_c && !ref_push_c) || (dut_push_req_c && !dut_push_c))) begin
                ovf_o <= 1'b1;
            end
            if (cmp_vld_q) begin
                if (commit_cnt_o != '1) commit_cnt_o <= commit_cnt_o + CNT_W'(1);
                if (cmp_mis_q) begin
                    if (mismatch_cnt_o != '1) mismatch_cnt_o <= mismatch_cnt_o + CNT_W'(1);
                    if (!err_o) begin
                        err_o           <= 1'b1;
                        err_pc_o        <= cmp_ref_q.pc;
                        err_ref_instr_o <= cmp_ref_q.instr;
                        err_dut_instr_o <= cmp_dut_instr_q;
                        err_ref_data_o  <= cmp_ref_q.data;
                        err_dut_data_o  <= cmp_dut_data_q;
                        err_ref_rd_o    <= cmp_ref_q.rd;
                        err_dut_rd_o    <= cmp_dut_rd_q;
                    end
                end
            end
        end
    end

`ifdef COMMIT_CMP_TIMEOUT_EN
    // Timeout counter: runs while exactly one side waits, clears otherwise in RUN.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            to_cnt_q <= '0;
            to_o     <= 1'b0;
        end else if (clr_i) begin
            to_cnt_q <= '0;
            to_o     <= 1'b0;
        end else begin
            if (to_wait_c) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end else if (state_q == ST_RUN) begin
                to_cnt_q <= '0;
            end
            if (to_hit_c) begin
                to_o <= 1'b1;
            end
        end
    end
`endif

endmodule
